// File: rtl/jstx_pkg.sv
// Shared types and constants for the JPEG block stream transmitter.
package jstx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_WT,
        HDR_TX,
        DAT_RD,
        DAT_WT,
        DAT_TX,
        DONE
    } state_t;

    localparam logic [15:0] EOI_MARKER = 16'hFFD9;
    localparam int          BLK_DIM    = 8;

endpackage

// File: rtl/jstx_blk_addr_gen.sv
// 8x8 block-raster address generator for the encoder buffer. je_addr always holds
// the address of the byte to be fetched next; last_pixel flags the final byte of the frame.
module jstx_blk_addr_gen
    import jstx_pkg::*;
#(
    parameter int IMG_W = 320,
    parameter int IMG_H = 200,
    parameter int BPP   = 2,
    parameter int JE_AW = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [JE_AW-1:0] je_addr,
    output logic             last_pixel
);

    localparam logic [2:0]  CNT_LAST  = 3'(BLK_DIM - 1);
    localparam logic [1:0]  BYTE_LAST = 2'(BPP - 1);
    localparam logic [15:0] W16       = 16'(IMG_W);
    localparam logic [15:0] H16       = 16'(IMG_H);
    localparam logic [15:0] BLK16     = 16'(BLK_DIM);

    logic [15:0]      row_base_reg, row_base_next;
    logic [15:0]      col_base_reg, col_base_next;
    logic [2:0]       row_reg, row_next;
    logic [2:0]       col_reg, col_next;
    logic [1:0]       byte_reg, byte_next;
    logic [JE_AW-1:0] je_addr_reg, je_addr_next;

    // Rows of a block stop early when the block hangs over the bottom image edge.
    always_comb begin
        row_base_next = row_base_reg;
        col_base_next = col_base_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        byte_next     = byte_reg;
        if (byte_reg != BYTE_LAST) begin
            byte_next = byte_reg + 2'd1;
        end else begin
            byte_next = 2'd0;
            if (col_reg != CNT_LAST) begin
                col_next = col_reg + 3'd1;
            end else begin
                col_next = 3'd0;
                if (row_reg != CNT_LAST && (row_base_reg + 16'(row_reg) + 16'd1) < H16) begin
                    row_next = row_reg + 3'd1;
                end else begin
                    row_next = 3'd0;
                    if (col_base_reg + BLK16 < W16) begin
                        col_base_next = col_base_reg + BLK16;
                    end else begin
                        col_base_next = 16'd0;
                        row_base_next = row_base_reg + BLK16;
                    end
                end
            end
        end
        je_addr_next = JE_AW'(((int'(row_base_next) + int'(row_next)) * IMG_W
                              + int'(col_base_next) + int'(col_next)) * BPP
                              + int'(byte_next));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row_base_reg <= 16'd0;
            col_base_reg <= 16'd0;
            row_reg      <= 3'd0;
            col_reg      <= 3'd0;
            byte_reg     <= 2'd0;
            je_addr_reg  <= '0;
        end else if (step) begin
            row_base_reg <= row_base_next;
            col_base_reg <= col_base_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            byte_reg     <= byte_next;
            je_addr_reg  <= je_addr_next;
        end
    end

    assign je_addr    = je_addr_reg;
    assign last_pixel = (byte_reg == BYTE_LAST) && (col_reg == CNT_LAST)
                     && (col_base_reg + BLK16 == W16)
                     && (row_base_reg + 16'(row_reg) == H16 - 16'd1);

endmodule

// File: rtl/jpeg_blk_stream_tx.sv
// Streams a JPEG header ROM followed by the encoded buffer in 8x8 block order.
// Macro JSTX_EOI_STOP_EN: when defined, the frame ends early on the first FF,D9 pair.
module jpeg_blk_stream_tx
    import jstx_pkg::*;
#(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 200,
    parameter int BPP      = 2,
    parameter int HDR_SIZE = 607,
    parameter int HDR_AW   = 10,
    parameter int JE_AW    = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              je_done,
    input  logic              abort,
    output logic [HDR_AW-1:0] hd_addr,
    input  logic [7:0]        hd_data,
    output logic [JE_AW-1:0]  je_addr,
    input  logic [7:0]        je_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    localparam logic [HDR_AW-1:0] HDR_LAST = HDR_AW'(HDR_SIZE - 1);

    state_t            state_reg, state_next;
    logic [7:0]        out_data_reg;
    logic [HDR_AW-1:0] hd_addr_reg;
    logic              out_last_reg;
    logic              accept, last_pixel, terminal, addr_step, addr_clear;

    assign accept = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (je_done) state_next = HDR_RD;
                HDR_RD:  state_next = HDR_WT;
                HDR_WT:  state_next = HDR_TX;
                HDR_TX:  if (accept) state_next = (hd_addr_reg == HDR_LAST) ? DAT_RD : HDR_RD;
                DAT_RD:  state_next = DAT_WT;
                DAT_WT:  state_next = DAT_TX;
                DAT_TX:  if (accept) state_next = out_last_reg ? DONE : DAT_RD;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_reg == HDR_TX) || (state_reg == DAT_TX);
        busy      = (state_reg != IDLE);
    end

`ifdef JSTX_EOI_STOP_EN
    // Remembers whether the last accepted byte (header or data) was 0xFF.
    logic prev_ff_reg;

    always_ff @(posedge clk) begin
        if (reset || abort || state_reg == DONE || state_reg == IDLE)
            prev_ff_reg <= 1'b0;
        else if (accept)
            prev_ff_reg <= (out_data_reg == EOI_MARKER[15:8]);
    end

    assign terminal = last_pixel || (prev_ff_reg && je_data == EOI_MARKER[7:0]);
`else
    assign terminal = last_pixel;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg <= 8'h00;
            hd_addr_reg  <= '0;
            out_last_reg <= 1'b0;
        end else if (abort) begin
            hd_addr_reg  <= '0;
            out_last_reg <= 1'b0;
        end else begin
            if (state_reg == HDR_WT)
                out_data_reg <= hd_data;
            else if (state_reg == DAT_WT)
                out_data_reg <= je_data;

            // out_last is decided while the byte is captured and lives only for its TX slot.
            if (state_reg == DAT_WT)
                out_last_reg <= terminal;
            else if (accept)
                out_last_reg <= 1'b0;

            if (state_reg == DONE)
                hd_addr_reg <= '0;
            else if (state_reg == HDR_TX && accept && hd_addr_reg != HDR_LAST)
                hd_addr_reg <= hd_addr_reg + 1'b1;
        end
    end

    assign addr_step  = (state_reg == DAT_TX) && accept && !out_last_reg;
    assign addr_clear = abort || (state_reg == DONE) || (state_reg == IDLE);

    jstx_blk_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .BPP   (BPP),
        .JE_AW (JE_AW)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (addr_clear),
        .step       (addr_step),
        .je_addr    (je_addr),
        .last_pixel (last_pixel)
    );

    assign out_data = out_data_reg;
    assign hd_addr  = hd_addr_reg;
    assign out_last = out_last_reg;

endmodule
